// File: rtl/shared_counter_sched_pkg.sv
// Shared types and sizing helpers for the round-robin interval-counter scheduler.
package shared_counter_sched_pkg;

   localparam int NREQ_DEF = 4;
   localparam int CW_DEF   = 4;
   localparam int IDW      = $clog2(NREQ_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Index width that never collapses to zero bits.
   function automatic int idw_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shared_counter_sched_if.sv
// Request/completion bundle between the clients and the shared counter scheduler.
interface shared_counter_sched_if
   import shared_counter_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int CW   = CW_DEF
);
   localparam int IW = idw_f(NREQ);

   logic [NREQ-1:0]    req;
   logic [NREQ*CW-1:0] len;
   logic               abort;
   logic [NREQ-1:0]    ack;
   logic [NREQ-1:0]    done;
   logic               aborted;
   logic               busy;
   logic [IW-1:0]      grant_id;
   logic [CW-1:0]      cnt_q;

   modport master (
      output req, len, abort,
      input  ack, done, aborted, busy, grant_id, cnt_q
   );

   modport slave (
      input  req, len, abort,
      output ack, done, aborted, busy, grant_id, cnt_q
   );

endinterface

// File: rtl/shared_counter_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request above ptr, wrapping around.
module rr_arbiter
   import shared_counter_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IW   = idw_f(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            valid
);

   int pos_s;

   // Scan NREQ slots starting just after ptr; the first hit wins.
   always_comb begin
      grant = {NREQ{1'b0}};
      idx   = {IW{1'b0}};
      valid = 1'b0;
      pos_s = 0;
      for (int k = 1; k <= NREQ; k++) begin
         pos_s = (int'(ptr) + k) % NREQ;
         if (!valid && req[pos_s]) begin
            valid        = 1'b1;
            idx          = IW'(pos_s);
            grant[pos_s] = 1'b1;
         end else begin
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/shared_counter_sched.sv
// Time-shares one CW-bit interval counter among NREQ requesters with round-robin arbitration.
module shared_counter_sched
   import shared_counter_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int CW   = CW_DEF
) (
   input logic                  clk,
   input logic                  reset,
   shared_counter_sched_if.slave bus
);

   localparam int IW = idw_f(NREQ);

   state_e          state_r;
   state_e          state_nxt_s;
   logic [IW-1:0]   rr_ptr_r;
   logic [IW-1:0]   grant_r;
   logic [CW-1:0]   tgt_r;
   logic [CW-1:0]   cnt_r;
   logic            aborted_r;

   logic [NREQ-1:0] arb_grant_s;
   logic [IW-1:0]   arb_idx_s;
   logic            arb_valid_s;
   logic [CW-1:0]   win_len_s;
   logic            last_s;

   logic [NREQ-1:0] ack_s;
   logic [NREQ-1:0] done_s;
   logic            aborted_s;
   logic            busy_s;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req   (bus.req),
      .ptr   (rr_ptr_r),
      .grant (arb_grant_s),
      .idx   (arb_idx_s),
      .valid (arb_valid_s)
   );

   assign win_len_s = bus.len[arb_idx_s*CW +: CW];
   assign last_s    = (cnt_r == (tgt_r - CW'(1)));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; abort takes precedence over the natural end of a run.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (arb_valid_s) begin
               state_nxt_s = (win_len_s != {CW{1'b0}}) ? RUN : DONE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (bus.abort || last_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Counter, target, owner and round-robin pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_r  <= IW'(NREQ - 1);
         grant_r   <= {IW{1'b0}};
         tgt_r     <= {CW{1'b0}};
         cnt_r     <= {CW{1'b0}};
         aborted_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (arb_valid_s) begin
                  grant_r   <= arb_idx_s;
                  tgt_r     <= win_len_s;
                  cnt_r     <= {CW{1'b0}};
                  aborted_r <= 1'b0;
               end
            end
            RUN: begin
               if (bus.abort) begin
                  aborted_r <= 1'b1;
               end else if (!last_s) begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            DONE: begin
               rr_ptr_r <= grant_r;
            end
            default: begin
               rr_ptr_r <= rr_ptr_r;
            end
         endcase
      end
   end

   // Output decode; ack is masked during reset so every output reads 0 immediately.
   always_comb begin
      ack_s     = {NREQ{1'b0}};
      done_s    = {NREQ{1'b0}};
      aborted_s = 1'b0;
      busy_s    = (state_r != IDLE);
      if ((state_r == IDLE) && arb_valid_s && !reset) begin
         ack_s = arb_grant_s;
      end else begin
         ack_s = {NREQ{1'b0}};
      end
      if (state_r == DONE) begin
         done_s[grant_r] = 1'b1;
         aborted_s       = aborted_r;
      end else begin
         aborted_s = 1'b0;
      end
   end

   assign bus.ack      = ack_s;
   assign bus.done     = done_s;
   assign bus.aborted  = aborted_s;
   assign bus.busy     = busy_s;
   assign bus.grant_id = grant_r;
   assign bus.cnt_q    = cnt_r;

endmodule

// File: tb/tb_shared_counter_sched.sv
// Self-checking bench: directed table, hand sequences and random traffic against a cycle-timeline model.
module tb_shared_counter_sched;

   localparam int NREQ = 4;
   localparam int CW   = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   shared_counter_sched_if #(.NREQ(NREQ), .CW(CW)) bus();
   shared_counter_sched #(.NREQ(NREQ), .CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Model: an accepted run of length L at cycle t ends with done at t+L+1 (earlier on abort).
   int m_cyc, m_ptr, m_gid, m_owner, m_start, m_done_at;
   bit m_active, m_ab;
   int ack_idx_q[$];
   int ack_cyc_q[$];

   function automatic int rr_pick(input logic [3:0] r, input int ptr);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr    = NREQ - 1;
      m_gid    = 0;
      m_active = 1'b0;
      m_ab     = 1'b0;
   endtask

   task automatic step(input logic [3:0] r, input logic [15:0] l, input logic a);
      int w;
      logic [3:0] e_ack, e_done;
      @(posedge clk);
      #1;
      bus.req   = r;
      bus.len   = l;
      bus.abort = a;
      @(negedge clk);
      w      = m_active ? -1 : rr_pick(r, m_ptr);
      e_ack  = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      e_done = (m_active && m_cyc == m_done_at) ? (4'b0001 << m_owner) : 4'b0000;
      check("ack", bus.ack, e_ack);
      check("done", bus.done, e_done);
      if (e_done != 4'b0000) check("aborted", bus.aborted, m_ab);
      check("busy", bus.busy, m_active);
      check("grant_id", bus.grant_id, m_gid);
      if (m_active && m_cyc != m_done_at) check("cnt_q", bus.cnt_q, m_cyc - m_start - 1);
      for (int i = 0; i < NREQ; i++) begin
         if (bus.ack[i]) begin
            ack_idx_q.push_back(i);
            ack_cyc_q.push_back(m_cyc);
         end
      end
      if (!m_active) begin
         if (w >= 0) begin
            m_active  = 1'b1;
            m_owner   = w;
            m_gid     = w;
            m_start   = m_cyc;
            m_done_at = m_cyc + int'(l[w*4 +: 4]) + 1;
            m_ab      = 1'b0;
         end
      end else if (m_cyc == m_done_at) begin
         m_active = 1'b0;
         m_ptr    = m_owner;
      end else if (a) begin
         m_done_at = m_cyc + 1;
         m_ab      = 1'b1;
      end
      m_cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.req = 4'b0000;
      bus.abort = 1'b0;
      @(posedge clk);
      #3;
      reset = 1'b0;
      model_reset();
   endtask

   // Accept requester 0 with length n, abort when cnt_q reaches at_cnt, expect aborted done.
   task automatic abort_seq(input string name, input logic [15:0] l, input int at_cnt);
      step(4'b0001, l, 1'b0);
      for (int k = 0; k < at_cnt; k++) step(4'b0000, l, 1'b0);
      step(4'b0000, l, 1'b1);
      check({name, "_cnt"}, bus.cnt_q, at_cnt);
      step(4'b0000, l, 1'b0);
      check({name, "_done"}, bus.done, 4'b0001);
      check({name, "_aborted"}, bus.aborted, 1'b1);
      step(4'b0000, l, 1'b0);
      check({name, "_idle"}, bus.busy, 1'b0);
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [15:0] len;
      logic [3:0]  ack;
      logic [3:0]  done;
      logic        busy;
      logic [1:0]  gid;
      logic        cc;
      logic [3:0]  cnt;
   } vec_t;

   vec_t tbl [9];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.req   = 4'b0000;
      bus.len   = 16'h0000;
      bus.abort = 1'b0;
      m_cyc     = 0;
      model_reset();

      // single request len 3 on requester 2, then zero-length on requester 1
      tbl[0] = '{4'b0100, 16'h0300, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0, 4'd0};
      tbl[1] = '{4'b0000, 16'h0300, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b1, 4'd0};
      tbl[2] = '{4'b0000, 16'h0300, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b1, 4'd1};
      tbl[3] = '{4'b0000, 16'h0300, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b1, 4'd2};
      tbl[4] = '{4'b0000, 16'h0300, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 4'd0};
      tbl[5] = '{4'b0000, 16'h0300, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 4'd0};
      tbl[6] = '{4'b0010, 16'hFF0F, 4'b0010, 4'b0000, 1'b0, 2'd2, 1'b0, 4'd0};
      tbl[7] = '{4'b0000, 16'hFF0F, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b1, 4'd0};
      tbl[8] = '{4'b0000, 16'hFF0F, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b1, 4'd0};

      #12;
      check("rst_ack", bus.ack, 4'b0000);
      check("rst_done", bus.done, 4'b0000);
      check("rst_aborted", bus.aborted, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_grant_id", bus.grant_id, 2'd0);
      check("rst_cnt_q", bus.cnt_q, 4'd0);
      @(posedge clk);
      #3;
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         step(tbl[i].req, tbl[i].len, 1'b0);
         check($sformatf("tbl%0d_ack", i), bus.ack, tbl[i].ack);
         check($sformatf("tbl%0d_done", i), bus.done, tbl[i].done);
         if (tbl[i].done != 4'b0000) check($sformatf("tbl%0d_aborted", i), bus.aborted, 1'b0);
         check($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].busy);
         check($sformatf("tbl%0d_gid", i), bus.grant_id, tbl[i].gid);
         if (tbl[i].cc) check($sformatf("tbl%0d_cnt", i), bus.cnt_q, tbl[i].cnt);
      end

      abort_seq("abort_mid", 16'h000A, 4);
      abort_seq("abort_last", 16'h0005, 4);

      // asynchronous reset in the middle of a len 8 run on requester 3
      step(4'b1000, 16'h8000, 1'b0);
      for (int k = 0; k < 6; k++) step(4'b0000, 16'h8000, 1'b0);
      check("midrun_cnt", bus.cnt_q, 4'd5);
      #2;
      reset   = 1'b1;
      bus.req = 4'b1001;
      #1;
      check("arst_ack", bus.ack, 4'b0000);
      check("arst_done", bus.done, 4'b0000);
      check("arst_busy", bus.busy, 1'b0);
      check("arst_grant_id", bus.grant_id, 2'd0);
      check("arst_cnt_q", bus.cnt_q, 4'd0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      model_reset();
      #1;
      check("rel_busy", bus.busy, 1'b0);
      check("rel_grant_id", bus.grant_id, 2'd0);
      check("rel_ack_first", bus.ack, 4'b0001);
      bus.req = 4'b0000;
      step(4'b1001, 16'h0000, 1'b0);
      check("post_rst_ack", bus.ack, 4'b0001);
      for (int k = 0; k < 4; k++) step(4'b0000, 16'h0000, 1'b0);

      // fairness with three requesters held high, len 1 each
      do_reset();
      ack_idx_q.delete();
      ack_cyc_q.delete();
      for (int k = 0; k < 18; k++) step(4'b1011, 16'h1111, 1'b0);
      check("fair_count", (ack_idx_q.size() >= 6), 1'b1);
      begin
         int exp_order [6] = '{0, 1, 3, 0, 1, 3};
         for (int k = 0; k < 6 && k < ack_idx_q.size(); k++) begin
            check($sformatf("fair_order%0d", k), ack_idx_q[k], exp_order[k]);
            if (k > 0) check($sformatf("fair_gap%0d", k), ack_cyc_q[k] - ack_cyc_q[k-1], 3);
         end
      end
      for (int k = 0; k < 4; k++) step(4'b0000, 16'h1111, 1'b0);

      // random traffic against the model
      do_reset();
      for (int k = 0; k < 600; k++) begin
         logic [3:0]  r;
         logic [15:0] l;
         logic        a;
         r = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         l = 16'($urandom);
         a = ($urandom_range(0, 11) == 0);
         step(r, l, a);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shared_counter_sched.md
Name: shared_counter_sched

Overview:
Round-robin scheduler that time-shares one CW-bit interval counter among NREQ requesters. Each requester asks for a run of len[i] clock cycles. The block arbitrates, loads and runs the counter for the winner, then signals completion to that requester. It sits between the up-counter datapath and client logic that needs timed intervals, so the design does not need one counter per client.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 4, counter width in bits; max interval is 2^CW-1 cycles

Ports:
clk  input  1  clock, rising edge
reset  input  1  reset, asynchronous, active-high
req  input  NREQ  per-requester request, level
len  input  NREQ*CW  interval length for requester i, at bits [i*CW +: CW]
abort  input  1  terminates the current run early
ack  output  NREQ  one-hot, 1-cycle pulse when a request is accepted
done  output  NREQ  one-hot, 1-cycle pulse when the owner's interval ends
aborted  output  1  valid with done; 1 = run ended by abort
busy  output  1  high in RUN and DONE
grant_id  output  $clog2(NREQ)  current or last owner index
cnt_q  output  CW  live counter value

Behaviour:
- Reset (async, active-high):
  - State = IDLE; all outputs 0.
  - Round-robin pointer rr_ptr = NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, RUN, DONE. Registered on the rising clk edge.
- IDLE:
  - If any req is high, select the winner by round-robin: the first set bit searching upward from rr_ptr+1, with wrap.
  - In the same cycle: assert ack[winner], latch grant_id = winner and tgt = len[winner], and clear cnt_q to 0.
  - Next state: RUN if tgt != 0, else DONE.
  - If no req is high: stay in IDLE; ack stays 0.
- RUN:
  - cnt_q increments by 1 each cycle.
  - When cnt_q == tgt-1, next state is DONE, so RUN lasts exactly tgt cycles with cnt_q = 0..tgt-1.
  - No wrap is possible because tgt <= 2^CW-1.
  - req and len changes are ignored during RUN.
- DONE (one cycle):
  - Assert done[grant_id].
  - aborted = 1 if entered via abort, else 0.
  - Set rr_ptr = grant_id; cnt_q holds its value.
  - Next state: IDLE.
- abort:
  - Honoured only in RUN. Next state is DONE with aborted = 1.
  - If abort arrives in the same cycle as cnt_q == tgt-1, abort wins and aborted = 1.
  - Ignored in IDLE and DONE.
- Timing:
  - Accept to done: tgt+1 cycles.
  - Back-to-back spacing from one ack to the next: tgt+2 cycles minimum, because IDLE is always visited for at least one cycle.
- Requester contract:
  - Deassert req in the cycle after ack.
  - A req still high after DONE is treated as a new request and competes normally.
  - Rotating rr_ptr guarantees no starvation.
- busy = (state != IDLE).
- grant_id holds its value in IDLE until the next accept.
- Reset mid-run: immediate return to IDLE. No done pulse, no ack pulse, rr_ptr is reinitialised, and cnt_q = 0.

Decomposition:
- Package shared_counter_sched_pkg holds:
  - state_e enum (IDLE, RUN, DONE)
  - localparam IDW = $clog2(NREQ)
- One natural sub-module, rr_arbiter. It is combinational: req vector and rr_ptr in, one-hot grant plus encoded index out. Instantiate it once.
- The FSM and counter stay in the top module.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately; after release, busy=0 and grant_id=0.
- Single request: req[2]=1, len[2]=3 -> ack[2] at T0; cnt_q = 0,1,2 on T1..T3; done[2] with aborted=0 at T4; busy falls at T5.
- Fairness: req[0], req[1] and req[3] held high permanently, each len=1 -> ack order 0,1,3,0,1,3; ack spacing is 3 cycles.
- Zero length: req[1]=1, len[1]=0 -> ack[1] at T0, done[1] at T1, no RUN cycles, cnt_q stays 0.
- Abort: len[0]=10; abort at cnt_q=4 -> done[0] with aborted=1 next cycle. Then abort coincident with cnt_q == tgt-1 on a len=5 run -> aborted=1.
- Reset mid-run: len[3]=8; reset at cnt_q=5 -> no done pulse; after release, req[0] and req[3] both high -> ack[0] first.
